// File: rtl/serial_asm_pkg.sv
// Shared types and sizing helpers for the serial word assembler.
// Holds the FSM state encoding, default parameter values and the counter-width helper.
package serial_asm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } asm_state_t;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_TIMEOUT = 16;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/serial_word_assembler_if.sv
// Bit-stream input, word handshake output and error flags of the serial word assembler.
// The master side is the stimulus/consumer; the slave side is the assembler itself.
interface serial_word_assembler_if #(
  parameter int WIDTH = 8
);

  logic             bit_in;
  logic             bit_valid;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             word_ready;
  logic             busy;
  logic             parity_err;
  logic             overrun;
  logic             frame_err;

  modport master (
    output bit_in,
    output bit_valid,
    output word_ready,
    input  word_out,
    input  word_valid,
    input  busy,
    input  parity_err,
    input  overrun,
    input  frame_err
  );

  modport slave (
    input  bit_in,
    input  bit_valid,
    input  word_ready,
    output word_out,
    output word_valid,
    output busy,
    output parity_err,
    output overrun,
    output frame_err
  );

endinterface

// File: rtl/serial_asm_shift_reg.sv
// MSB-first shift register that also tracks the XOR of every bit shifted in since the last clear.
module serial_asm_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_shift,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_data,
  output logic             o_parity
);

  logic [WIDTH-1:0] r_data;
  logic             r_parity;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data   <= '0;
      r_parity <= 1'b0;
    end else if (i_clr) begin
      r_data   <= '0;
      r_parity <= 1'b0;
    end else if (i_shift) begin
      r_data   <= {r_data[WIDTH-2:0], i_bit};
      r_parity <= r_parity ^ i_bit;
    end
  end

  assign o_data   = r_data;
  assign o_parity = r_parity;

endmodule

// File: rtl/serial_word_assembler.sv
// Deserialises a start-bit framed, MSB-first bit stream into parallel words with optional
// even parity, an inter-bit timeout and a valid/ready output holding one pending word.
module serial_word_assembler
  import serial_asm_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int PARITY_EN = 1,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  serial_word_assembler_if.slave bus
);

  localparam int CW = cnt_w(WIDTH - 1);
  localparam int TW = cnt_w(TIMEOUT);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  asm_state_t       r_state, w_state_nxt;
  logic [CW-1:0]    r_bit_cnt, w_bit_cnt_nxt;
  logic [TW-1:0]    r_to_cnt, w_to_cnt_nxt;
  logic             w_clr, w_shift, w_complete, w_par_fail, w_timeout;
  logic [WIDTH-1:0] w_word_nxt;
  logic [WIDTH-1:0] w_data;
  logic             w_parity;

  logic [WIDTH-1:0] r_word;
  logic             r_valid;
  logic             r_parity_err, r_overrun, r_frame_err;

  serial_asm_shift_reg #(.WIDTH(WIDTH)) u_shift (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_clr),
    .i_shift  (w_shift),
    .i_bit    (bus.bit_in),
    .o_data   (w_data),
    .o_parity (w_parity)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_to_cnt_nxt  = r_to_cnt;
    w_clr         = 1'b0;
    w_shift       = 1'b0;
    w_complete    = 1'b0;
    w_par_fail    = 1'b0;
    w_timeout     = 1'b0;
    w_word_nxt    = w_data;

    case (r_state)
      IDLE: begin
        w_to_cnt_nxt = '0;
        if (bus.bit_valid && bus.bit_in) begin
          w_state_nxt   = SHIFT;
          w_bit_cnt_nxt = '0;
          w_clr         = 1'b1;
        end
      end
      SHIFT: begin
        if (bus.bit_valid) begin
          w_shift       = 1'b1;
          w_to_cnt_nxt  = '0;
          w_bit_cnt_nxt = r_bit_cnt + CW'(1);
          if (r_bit_cnt == LAST_BIT) begin
            if (PARITY_EN != 0) begin
              w_state_nxt = PARITY;
            end else begin
              // Without parity the word is the register contents plus the bit arriving now.
              w_complete  = 1'b1;
              w_word_nxt  = {w_data[WIDTH-2:0], bus.bit_in};
              w_state_nxt = IDLE;
            end
          end
        end
      end
      PARITY: begin
        if (bus.bit_valid) begin
          w_to_cnt_nxt = '0;
          w_state_nxt  = IDLE;
          if (w_parity ^ bus.bit_in) w_par_fail = 1'b1;
          else                       w_complete = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Inter-bit gap watchdog, only meaningful while a frame is in flight.
    if ((r_state != IDLE) && !bus.bit_valid) begin
      if (r_to_cnt == TO_LAST) begin
        w_timeout    = 1'b1;
        w_to_cnt_nxt = '0;
        w_state_nxt  = IDLE;
      end else begin
        w_to_cnt_nxt = r_to_cnt + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_to_cnt  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_to_cnt  <= w_to_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_word       <= '0;
      r_valid      <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_parity_err <= w_par_fail;
      r_frame_err  <= w_timeout;
      r_overrun    <= w_complete && r_valid && !bus.word_ready;
      // A completion on the transfer edge reloads the slot instead of overrunning it.
      if (w_complete && (!r_valid || bus.word_ready)) begin
        r_word  <= w_word_nxt;
        r_valid <= 1'b1;
      end else if (r_valid && bus.word_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.word_out   = r_word;
  assign bus.word_valid = r_valid;
  assign bus.busy       = (r_state == SHIFT) || (r_state == PARITY);
  assign bus.parity_err = r_parity_err;
  assign bus.overrun    = r_overrun;
  assign bus.frame_err  = r_frame_err;

endmodule
